// File: rtl/cvm_pkg.sv
// Shared vending-machine types: dispenser FSM states, channel codes, coin values.
package cvm_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PULSE = 3'd1,
    GAP   = 3'd2,
    WAIT  = 3'd3,
    FAULT = 3'd4
  } disp_state_e;

  // Channel code doubles as the pending-counter index.
  typedef enum logic [1:0] {
    CH_P = 2'd0,
    CH_D = 2'd1,
    CH_N = 2'd2
  } chan_e;

  localparam int unsigned NICKEL_VAL  = 5;
  localparam int unsigned DIME_VAL    = 10;
  localparam int unsigned QUARTER_VAL = 25;
  localparam int unsigned PRICE_VAL   = 15;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pend_counter.sv
// Saturating per-channel pending-command counter; simultaneous inc/dec cancel.
module pend_counter #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             at_max
);

  assign at_max = (cnt == {CNT_W{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && !dec && !at_max) begin
      cnt <= cnt + CNT_W'(1);
    end else if (dec && !inc && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/coin_dispenser.sv
// Converts one-cycle dispense commands into spaced solenoid pulses.
// Optional chute-sensor confirmation when COIN_DISPENSE_SENSE_EN is defined.
module coin_dispenser
  import cvm_pkg::*;
#(
  parameter int unsigned PULSE_W = 4,
  parameter int unsigned GAP_W   = 2,
  parameter int unsigned CNT_W   = 3,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic del_req,
  input  logic rn_req,
  input  logic rd_req,
  input  logic coin_seen,
  output logic p_sol,
  output logic n_sol,
  output logic d_sol,
  output logic busy,
  output logic ovf,
  output logic fault
);

  localparam int unsigned PH_MAX = max3(PULSE_W, GAP_W, TIMEOUT);
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

  disp_state_e      state, state_nxt;
  chan_e            ch, ch_nxt;
  logic [PH_W-1:0]  phase, phase_nxt;
  logic [2:0]       inc, dec, at_max, nz, pend_nxt;
  logic [CNT_W-1:0] cnt [3];
  logic             p_nxt, n_nxt, d_nxt, busy_nxt, ovf_nxt;

  assign inc = {rn_req, rd_req, del_req};

  for (genvar i = 0; i < 3; i++) begin : g_cnt
    pend_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .inc    (inc[i]),
      .dec    (dec[i]),
      .cnt    (cnt[i]),
      .at_max (at_max[i])
    );
    assign nz[i] = (cnt[i] != '0);
  end

  // State, channel, phase and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ch    <= CH_P;
      phase <= '0;
      p_sol <= 1'b0;
      n_sol <= 1'b0;
      d_sol <= 1'b0;
      busy  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      ch    <= ch_nxt;
      phase <= phase_nxt;
      p_sol <= p_nxt;
      n_sol <= n_nxt;
      d_sol <= d_nxt;
      busy  <= busy_nxt;
      ovf   <= ovf_nxt;
    end
  end

  // Next state; channel selection and counter decrement happen on IDLE exit
  always_comb begin
    state_nxt = state;
    ch_nxt    = ch;
    phase_nxt = phase;
    dec       = 3'b000;
    case (state)
      IDLE: begin
        if (nz != 3'b000) begin
          state_nxt = PULSE;
          phase_nxt = '0;
          if (nz[0]) begin
            ch_nxt = CH_P;
            dec[0] = 1'b1;
          end else if (nz[1]) begin
            ch_nxt = CH_D;
            dec[1] = 1'b1;
          end else begin
            ch_nxt = CH_N;
            dec[2] = 1'b1;
          end
        end
      end
      PULSE: begin
        if (phase == PH_W'(PULSE_W - 1)) begin
          state_nxt = GAP;
          phase_nxt = '0;
        end else begin
          phase_nxt = phase + PH_W'(1);
        end
      end
      GAP: begin
        if (phase == PH_W'(GAP_W - 1)) begin
`ifdef COIN_DISPENSE_SENSE_EN
          state_nxt = WAIT;
`else
          state_nxt = IDLE;
`endif
          phase_nxt = '0;
        end else begin
          phase_nxt = phase + PH_W'(1);
        end
      end
`ifdef COIN_DISPENSE_SENSE_EN
      WAIT: begin
        if (coin_seen) begin
          state_nxt = IDLE;
          phase_nxt = '0;
        end else if (phase == PH_W'(TIMEOUT - 1)) begin
          state_nxt = FAULT;
          phase_nxt = '0;
        end else begin
          phase_nxt = phase + PH_W'(1);
        end
      end
      FAULT: state_nxt = FAULT;
`endif
      default: begin
        state_nxt = IDLE;
        phase_nxt = '0;
      end
    endcase
  end

  // Output next-values are derived from next state so the solenoid rises with PULSE entry
  always_comb begin
    p_nxt    = 1'b0;
    n_nxt    = 1'b0;
    d_nxt    = 1'b0;
    pend_nxt = 3'b000;
    if (state_nxt == PULSE) begin
      p_nxt = (ch_nxt == CH_P);
      d_nxt = (ch_nxt == CH_D);
      n_nxt = (ch_nxt == CH_N);
    end
    for (int i = 0; i < 3; i++) begin
      pend_nxt[i] = (inc[i] && !dec[i]) ||
                    (nz[i] && !(dec[i] && !inc[i] && (cnt[i] == CNT_W'(1))));
    end
    busy_nxt = (state_nxt != IDLE) || (pend_nxt != 3'b000);
    ovf_nxt  = ovf || ((inc & at_max & ~dec) != 3'b000);
  end

`ifdef COIN_DISPENSE_SENSE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fault <= 1'b0;
    end else begin
      fault <= (state_nxt == FAULT);
    end
  end
`else
  logic unused_sense;
  assign unused_sense = coin_seen;
  assign fault        = 1'b0;
`endif

endmodule
